// File: rtl/i_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its IF/ID register.
package i_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll r0,r0,0

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // IF/ID bundle, layout shared with the decode-stage register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // Bubble entry: NOP instruction, zero npc, not valid.
  function automatic if_id_t make_bubble(input logic [31:0] nop);
    if_id_t b;
    b.instr = nop;
    b.npc   = 32'h0000_0000;
    b.valid = 1'b0;
    return b;
  endfunction

  // Sequential PC increment, modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/i_fetch_if_id.sv
// IF/ID pipeline register with load, hold and flush controls (flush wins).
module i_fetch_if_id
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [IF_ID_W-1:0] din,
  output logic [IF_ID_W-1:0] dout
);

  if_id_t data_r;

  // Pipeline register: flush inserts a bubble, load captures din, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= make_bubble(NOP_INSTR);
    end else if (flush) begin
      data_r <= make_bubble(NOP_INSTR);
    end else if (load) begin
      data_r <= if_id_t'(din);
    end else begin
      data_r <= data_r;
    end
  end

  assign dout = data_r;

endmodule

// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and the IF/ID register.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instruction_out,
  output logic [31:0] IF_ID_npc_out,
  output logic        IF_ID_valid
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  req_addr_r, req_addr_s;
  logic [31:0]  skid_instr_r, skid_instr_s;
  logic [31:0]  skid_npc_r, skid_npc_s;
  logic         req_r, req_s;
  logic [31:0]  addr_r, addr_s;
  logic         ifid_load_s, ifid_flush_s;
  if_id_t       ifid_din_s, ifid_q_s;
  logic [31:0]  target_s;

  // Low two bits of the redirect address are forced to zero (word aligned).
  assign target_s = branch_target & 32'hFFFF_FFFC;

  // Next-state, PC, skid and IF/ID control decode.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_addr_s   = req_addr_r;
    skid_instr_s = skid_instr_r;
    skid_npc_s   = skid_npc_r;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_din_s.instr = imem_rdata;
    ifid_din_s.npc   = pc_plus4(pc_r);
    ifid_din_s.valid = 1'b1;

    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
      end
      ST_REQ: begin
        if (pc_src) begin
          ifid_flush_s = 1'b1;
          pc_s         = target_s;
          if (imem_valid) begin
            state_s = ST_REQ;
          end else begin
            req_addr_s = pc_r;
            state_s    = ST_DRAIN;
          end
        end else if (imem_valid && !stall) begin
          ifid_load_s = 1'b1;
          pc_s        = pc_plus4(pc_r);
        end else if (imem_valid) begin
          skid_instr_s = imem_rdata;
          skid_npc_s   = pc_plus4(pc_r);
          state_s      = ST_HOLD;
        end else if (!stall) begin
          ifid_flush_s = 1'b1;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (pc_src) begin
          ifid_flush_s = 1'b1;
          pc_s         = target_s;
          state_s      = ST_REQ;
        end else if (!stall) begin
          ifid_load_s      = 1'b1;
          ifid_din_s.instr = skid_instr_r;
          ifid_din_s.npc   = skid_npc_r;
          pc_s             = pc_plus4(pc_r);
          state_s          = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The abandoned request's data is never loaded; redirect or no stall flushes.
        if (pc_src) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (pc_src || !stall) begin
          ifid_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b0;
        end
        if (imem_valid) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Request/address for the coming cycle, so the memory interface is driven from flops.
  always_comb begin
    req_s  = (state_s == ST_REQ) || (state_s == ST_DRAIN);
    addr_s = pc_s;
    if (state_s == ST_DRAIN) begin
      addr_s = req_addr_s;
    end else begin
      addr_s = pc_s;
    end
  end

  // Fetch state, PC, held address, skid buffer and memory-interface registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      skid_instr_r <= 32'h0000_0000;
      skid_npc_r   <= 32'h0000_0000;
      req_r        <= 1'b0;
      addr_r       <= RESET_PC;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_addr_r   <= req_addr_s;
      skid_instr_r <= skid_instr_s;
      skid_npc_r   <= skid_npc_s;
      req_r        <= req_s;
      addr_r       <= addr_s;
    end
  end

  i_fetch_if_id #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ifid_load_s),
    .flush(ifid_flush_s),
    .din  (ifid_din_s),
    .dout (ifid_q_s)
  );

  assign imem_req              = req_r;
  assign imem_addr             = addr_r;
  assign IF_ID_instruction_out = ifid_q_s.instr;
  assign IF_ID_npc_out         = ifid_q_s.npc;
  assign IF_ID_valid           = ifid_q_s.valid;

endmodule

// File: tb/tb_i_fetch.sv
// Directed self-checking bench for the instruction-fetch stage.
module tb_i_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_instruction_out;
  logic [31:0] IF_ID_npc_out;
  logic        IF_ID_valid;

  int n_checks = 0;
  int n_errors = 0;

  i_fetch dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall                (stall),
    .pc_src               (pc_src),
    .branch_target        (branch_target),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_valid           (imem_valid),
    .imem_rdata           (imem_rdata),
    .IF_ID_instruction_out(IF_ID_instruction_out),
    .IF_ID_npc_out        (IF_ID_npc_out),
    .IF_ID_valid          (IF_ID_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] npc, input logic valid);
    check_eq({tag, ".instr"}, IF_ID_instruction_out, instr);
    check_eq({tag, ".npc"}, IF_ID_npc_out, npc);
    check_eq({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
  endtask

  task automatic check_mem(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic st,
                       input logic ps, input logic [31:0] tgt);
    imem_valid    = v;
    imem_rdata    = d;
    stall         = st;
    pc_src        = ps;
    branch_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_mem("reset", 1'b0, 32'h0);
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // 1: zero-wait fetch from reset
    drive(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
    tick();  // IDLE -> REQ
    check_mem("t1_a0", 1'b1, 32'h0000_0000);
    check_ifid("t1_idle", 32'h0, 32'h0, 1'b0);
    tick();
    check_mem("t1_a4", 1'b1, 32'h0000_0004);
    check_ifid("t1_i0", 32'h2001_0005, 32'h0000_0004, 1'b1);
    drive(1'b1, 32'h2002_0007, 1'b0, 1'b0, 32'h0);
    tick();
    check_mem("t1_a8", 1'b1, 32'h0000_0008);
    check_ifid("t1_i1", 32'h2002_0007, 32'h0000_0008, 1'b1);
    drive(1'b1, 32'h2003_0009, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h2004_000B, 1'b0, 1'b0, 32'h0);
    tick();
    check_mem("t1_a10", 1'b1, 32'h0000_0010);
    check_ifid("t1_i3", 32'h2004_000B, 32'h0000_0010, 1'b1);

    // 2: stall while data returns -> HOLD, then release
    drive(1'b1, 32'hAC43_0000, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
      check_mem("t2_hold", 1'b0, 32'h0);
      check_ifid("t2_hold", 32'h2004_000B, 32'h0000_0010, 1'b1);
    end
    drive(1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("t2_rel", 32'hAC43_0000, 32'h0000_0014, 1'b1);
    check_mem("t2_a14", 1'b1, 32'h0000_0014);

    // 3: two wait cycles give bubbles with address held
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("t3_bub.instr", IF_ID_instruction_out, 32'h0);
      check_eq("t3_bub.valid", {31'd0, IF_ID_valid}, 32'd0);
      check_mem("t3_held", 1'b1, 32'h0000_0014);
    end
    drive(1'b1, 32'h2005_000D, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("t3_i", 32'h2005_000D, 32'h0000_0018, 1'b1);
    drive(1'b1, 32'h2006_000F, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h2007_0011, 1'b0, 1'b0, 32'h0);
    tick();
    check_mem("t3_a20", 1'b1, 32'h0000_0020);

    // 4: redirect while request at 0x20 pending -> DRAIN
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0043);
    tick();
    check_ifid("t4_flush", 32'h0, 32'h0, 1'b0);
    check_mem("t4_drain0", 1'b1, 32'h0000_0020);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check_mem("t4_drain1", 1'b1, 32'h0000_0020);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    check_mem("t4_a40", 1'b1, 32'h0000_0040);
    check_ifid("t4_drop", 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'h2008_0013, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("t4_i40", 32'h2008_0013, 32'h0000_0044, 1'b1);

    // 5: redirect together with stall (and valid data) still flushes
    drive(1'b1, 32'hBAD0_0000, 1'b1, 1'b1, 32'h0000_0100);
    tick();
    check_ifid("t5_flush", 32'h0, 32'h0, 1'b0);
    check_mem("t5_a100", 1'b1, 32'h0000_0100);

    // 6: PC wrap at 0xFFFF_FFFC (target low bits ignored)
    drive(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    check_mem("t6_afffc", 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 32'h2009_0015, 1'b0, 1'b0, 32'h0);
    tick();
    check_ifid("t6_wrap", 32'h2009_0015, 32'h0000_0000, 1'b1);
    check_mem("t6_a0", 1'b1, 32'h0000_0000);

    // Reset asserted mid-DRAIN
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
    tick();
    check_mem("t6_drain", 1'b1, 32'h0000_0000);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_mem("t6_rst", 1'b0, 32'h0);
    check_eq("t6_rst.addr", imem_addr, 32'h0);
    check_ifid("t6_rst", 32'h0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check_mem("t6_restart", 1'b1, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i_fetch.md
Name: i_fetch

Overview:
- Instruction-fetch stage (IF) of the 5-stage MIPS pipeline.
- Owns the PC, issues requests to instruction memory over a valid/ready-style handshake, and holds the IF/ID pipeline register.
- IF_ID_instruction_out and IF_ID_npc_out feed the decode stage directly.
- Honours a hazard-unit stall and a branch redirect from MEM. Redirect flushes IF/ID to a NOP bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction inserted into IF/ID (sll r0,r0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- pc_src  input  1  MEM stage: branch taken, redirect fetch.
- branch_target  input  32  redirect address; bits [1:0] ignored and treated as 0.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch word address. Must stay stable while imem_req=1 until imem_valid.
- imem_valid  input  1  read data valid. May assert in the same cycle as imem_req (zero-wait).
- imem_rdata  input  32  instruction word; sampled only when imem_req && imem_valid.
- IF_ID_instruction_out  output  32  registered instruction to decode.
- IF_ID_npc_out  output  32  registered PC+4 of that instruction.
- IF_ID_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
Reset (async, rst_n=0):
- state=IDLE, pc=RESET_PC, skid empty.
- IF_ID_instruction_out=NOP_INSTR, IF_ID_npc_out=0, IF_ID_valid=0.
- imem_req=0.

State machine. imem_req=1 in REQ and DRAIN, otherwise 0. imem_addr = pc in REQ, req_addr in DRAIN.
- IDLE: go to REQ after one cycle. IF/ID holds the bubble.
- REQ, evaluated in priority order:
  1. pc_src=1: IF/ID <= bubble, pc <= {branch_target[31:2],2'b00}. If imem_valid=1, data is discarded and state stays REQ. Otherwise req_addr <= old pc and state goes to DRAIN.
  2. imem_valid=1 and stall=0: IF/ID <= {imem_rdata, pc+4, 1}, pc <= pc+4, stay in REQ. This gives back-to-back throughput of 1 instruction per cycle.
  3. imem_valid=1 and stall=1: skid <= {imem_rdata, pc+4}, IF/ID unchanged, go to HOLD.
  4. imem_valid=0 and stall=0: IF/ID <= bubble, pc unchanged.
  5. imem_valid=0 and stall=1: IF/ID unchanged, pc unchanged.
- HOLD (no request outstanding):
  - pc_src=1: skid discarded, IF/ID <= bubble, pc <= target, go to REQ.
  - stall=0: IF/ID <= {skid, 1}, pc <= pc+4, go to REQ.
  - stall=1: remain in HOLD.
- DRAIN (abandoned request still outstanding, address held):
  - imem_valid=1: data discarded, go to REQ with the redirected pc.
  - A further pc_src=1 in DRAIN overwrites pc with the newest target.
  - stall=0: IF/ID <= bubble each cycle. stall=1: IF/ID held.

Arithmetic and priority:
- pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Redirect beats stall. pc_src together with stall still flushes IF/ID.

Latency:
- Instruction returned in cycle N (imem_valid) appears on IF_ID_* after edge N+1.
- Redirect in cycle N puts the target address on imem_addr in cycle N+1, or after DRAIN completes.

Reset mid-operation:
- Outstanding request and skid are abandoned immediately.
- Memory side must tolerate an imem_req drop without imem_valid.

Decomposition:
- Shared package: NOP_INSTR, RESET_PC default, FSM state encoding (IDLE, REQ, HOLD, DRAIN), and the IF/ID bundle layout (instr 32, npc 32, valid 1), shared with the decode-stage register.
- One natural sub-module, if_id: the IF/ID register with load, hold and flush controls, mirroring the existing ID/EX register.

Test Plan:
1. Reset release with zero-wait memory returning 32'h2001_0005, 32'h2002_0007 at 0x0, 0x4. Expect imem_addr 0x0, 0x4, 0x8 on consecutive cycles; IF/ID = {20010005, 00000004, 1} then {20020007, 00000008, 1}.
2. Stall=1 for 3 cycles while imem_valid=1 at pc 0x10 with data 32'hAC43_0000. Expect IF/ID unchanged and imem_req=0 during HOLD; on release IF/ID = {AC430000, 00000014, 1} and next imem_addr=0x14.
3. Memory wait of 2 cycles with stall=0. Expect two bubble cycles (valid=0, instr=0) and imem_addr held constant.
4. pc_src=1 with branch_target=0x0000_0043 while a request at 0x20 is pending. Expect IF/ID flushed the next cycle and DRAIN holds addr 0x20 until valid. The 0x20 data is dropped, the next request goes to 0x40, and no instruction from 0x20 reaches IF/ID.
5. pc_src=1 and stall=1 in the same cycle. Expect IF/ID flushed to bubble and pc=target.
6. PC at 0xFFFF_FFFC fetched. Expect IF_ID_npc_out=0x0000_0000 and next imem_addr=0x0. Also assert rst_n low mid-DRAIN: expect imem_req=0 immediately and outputs at their reset values.
